// File: rtl/wb_stage_pkg.sv
// Shared constants and the W-register record for the writeback stage.
package wb_stage_pkg;

   localparam int XLEN = 32;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd1;
   localparam logic [1:0] WB_PC8  = 2'd2;
   localparam logic [1:0] WB_RSVD = 2'd3;

   localparam logic [2:0] LD_LW  = 3'd0;
   localparam logic [2:0] LD_LB  = 3'd1;
   localparam logic [2:0] LD_LBU = 3'd2;
   localparam logic [2:0] LD_LH  = 3'd3;
   localparam logic [2:0] LD_LHU = 3'd4;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic            reg_write;
      logic [4:0]      reg_addr;
      logic [1:0]      wb_sel;
      logic [XLEN-1:0] alu_result;
      logic [XLEN-1:0] mem_rdata;
      logic [2:0]      load_type;
   } w_reg_t;

   localparam w_reg_t W_BUBBLE = '0;

endpackage

// File: rtl/wb_stage_load_ext.sv
// Load data extraction: picks the byte/halfword lane, extends it, and flags
// addresses that are not aligned for the access size.
module load_ext
   import wb_stage_pkg::*;
(
   input  logic [2:0]      load_type,
   input  logic [1:0]      byte_off,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] data,
   output logic            misaligned
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   always_comb begin
      byte_lane  = rdata[8*byte_off +: 8];
      half_lane  = byte_off[1] ? rdata[31:16] : rdata[15:0];
      data       = rdata;
      misaligned = 1'b0;
      case (load_type)
         LD_LB:   data = {{24{byte_lane[7]}}, byte_lane};
         LD_LBU:  data = {24'd0, byte_lane};
         LD_LH: begin
            data       = {{16{half_lane[15]}}, half_lane};
            misaligned = byte_off[0];
         end
         LD_LHU: begin
            data       = {16'd0, half_lane};
            misaligned = byte_off[0];
         end
         // LW and the unused encodings 5-7 take the whole word
         default: misaligned = (byte_off != 2'd0);
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: W pipeline register, result select, register-file write
// strobe, sticky misaligned-load flag and retired-instruction counter.
module wb_stage
   import wb_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h00003000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            flush,
   input  logic            m_valid,
   input  logic [XLEN-1:0] m_pc,
   input  logic            m_reg_write,
   input  logic [4:0]      m_reg_addr,
   input  logic [1:0]      m_wb_sel,
   input  logic [XLEN-1:0] m_alu_result,
   input  logic [XLEN-1:0] m_mem_rdata,
   input  logic [2:0]      m_load_type,
   output logic            reg_write,
   output logic [4:0]      reg_addr,
   output logic [XLEN-1:0] reg_data,
   output logic [XLEN-1:0] pc,
   output logic            w_valid,
   output logic            misalign,
   output logic [XLEN-1:0] retire_cnt
);

   w_reg_t          w_q, w_d;
   logic            misalign_q, misalign_d;
   logic [XLEN-1:0] retire_cnt_q, retire_cnt_d;

   logic [XLEN-1:0] ext_data;
   logic            ext_misaligned;
   logic            load_misaligned;
   logic [XLEN-1:0] sel_data;

   load_ext u_load_ext (
      .load_type  (w_q.load_type),
      .byte_off   (w_q.alu_result[1:0]),
      .rdata      (w_q.mem_rdata),
      .data       (ext_data),
      .misaligned (ext_misaligned)
   );

   always_comb begin
      load_misaligned = w_q.valid && (w_q.wb_sel == WB_MEM) && ext_misaligned;

      case (w_q.wb_sel)
         WB_MEM:  sel_data = ext_data;
         WB_PC8:  sel_data = w_q.pc + 32'd8;
         default: sel_data = w_q.alu_result;
      endcase

      // a held instruction keeps its strobe up; rewriting the same value is harmless
      reg_write  = w_q.valid & w_q.reg_write & (w_q.reg_addr != 5'd0) & ~load_misaligned;
      reg_addr   = reg_write ? w_q.reg_addr : 5'd0;
      reg_data   = reg_write ? sel_data : '0;
      pc         = w_q.valid ? w_q.pc : RESET_PC;
      w_valid    = w_q.valid;
      misalign   = misalign_q;
      retire_cnt = retire_cnt_q;
   end

   always_comb begin
      w_d          = w_q;
      retire_cnt_d = retire_cnt_q;
      misalign_d   = misalign_q | load_misaligned;
      if (flush) begin
         w_d = W_BUBBLE;
      end else if (en) begin
         w_d.valid      = m_valid;
         w_d.pc         = m_pc;
         w_d.reg_write  = m_reg_write;
         w_d.reg_addr   = m_reg_addr;
         w_d.wb_sel     = m_wb_sel;
         w_d.alu_result = m_alu_result;
         w_d.mem_rdata  = m_mem_rdata;
         w_d.load_type  = m_load_type;
         if (m_valid) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         w_q          <= W_BUBBLE;
         misalign_q   <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         w_q          <= w_d;
         misalign_q   <= misalign_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vector table, hand sequences for
// hold/flush/reset/misalign, and randomized traffic against a reference model.
module tb_wb_stage;

   localparam logic [31:0] RESET_PC = 32'h00003000;

   logic        clk = 1'b0;
   logic        reset, en, flush;
   logic        m_valid, m_reg_write;
   logic [31:0] m_pc, m_alu_result, m_mem_rdata;
   logic [4:0]  m_reg_addr;
   logic [1:0]  m_wb_sel;
   logic [2:0]  m_load_type;
   logic        reg_write, w_valid, misalign;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data, pc, retire_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .m_valid(m_valid), .m_pc(m_pc), .m_reg_write(m_reg_write),
      .m_reg_addr(m_reg_addr), .m_wb_sel(m_wb_sel),
      .m_alu_result(m_alu_result), .m_mem_rdata(m_mem_rdata),
      .m_load_type(m_load_type),
      .reg_write(reg_write), .reg_addr(reg_addr), .reg_data(reg_data),
      .pc(pc), .w_valid(w_valid), .misalign(misalign), .retire_cnt(retire_cnt)
   );

   // ---------------- reference model ----------------
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        rw;
      logic [4:0]  ra;
      logic [1:0]  sel;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [2:0]  lt;
   } instr_t;

   typedef struct packed {
      logic        rw;
      logic [4:0]  ra;
      logic [31:0] data;
      logic [31:0] pc;
      logic        valid;
      logic        mis_now;
   } exp_t;

   instr_t      mdl_w;
   logic        mdl_mis;
   logic [31:0] mdl_cnt;

   function automatic logic [31:0] extend(logic [31:0] raw, int bits, bit sgn);
      logic [31:0] mask;
      logic [31:0] v;
      mask = (32'd1 << bits) - 32'd1;
      v    = raw & mask;
      if (sgn && v[bits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic exp_t predict(instr_t w);
      exp_t        e;
      int          off;
      int          lt;
      logic [31:0] result;
      off = int'(w.alu % 4);
      lt  = (w.lt > 3'd4) ? 0 : int'(w.lt);
      e.mis_now = w.valid && (w.sel == 2'd1) &&
                  (((lt == 3 || lt == 4) && (off % 2 != 0)) || (lt == 0 && off != 0));
      if (w.sel == 2'd2)      result = w.pc + 32'd8;
      else if (w.sel == 2'd1) begin
         if (lt == 1 || lt == 2)      result = extend(w.rdata >> (8 * off), 8, lt == 1);
         else if (lt == 3 || lt == 4) result = extend(w.rdata >> (16 * (off / 2)), 16, lt == 3);
         else                         result = w.rdata;
      end else                result = w.alu;
      e.rw    = w.valid && w.rw && (w.ra != 5'd0) && !e.mis_now;
      e.ra    = e.rw ? w.ra : 5'd0;
      e.data  = e.rw ? result : 32'd0;
      e.pc    = w.valid ? w.pc : RESET_PC;
      e.valid = w.valid;
      return e;
   endfunction

   // advance the model by one edge using the inputs currently driven
   task automatic model_edge();
      exp_t cur;
      cur = predict(mdl_w);
      if (reset) begin
         mdl_w   = '0;
         mdl_mis = 1'b0;
         mdl_cnt = 32'd0;
      end else begin
         if (cur.mis_now) mdl_mis = 1'b1;
         if (flush) mdl_w = '0;
         else if (en) begin
            mdl_w = '{m_valid, m_pc, m_reg_write, m_reg_addr, m_wb_sel,
                      m_alu_result, m_mem_rdata, m_load_type};
            if (m_valid) mdl_cnt = mdl_cnt + 32'd1;
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_model(string tag);
      exp_t e;
      e = predict(mdl_w);
      chk({tag, ".reg_write"},  {31'd0, reg_write}, {31'd0, e.rw});
      chk({tag, ".reg_addr"},   {27'd0, reg_addr},  {27'd0, e.ra});
      chk({tag, ".reg_data"},   reg_data,           e.data);
      chk({tag, ".pc"},         pc,                 e.pc);
      chk({tag, ".w_valid"},    {31'd0, w_valid},   {31'd0, e.valid});
      chk({tag, ".misalign"},   {31'd0, misalign},  {31'd0, mdl_mis});
      chk({tag, ".retire_cnt"}, retire_cnt,         mdl_cnt);
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic v, logic [31:0] p, logic rw, logic [4:0] ra,
                        logic [1:0] sel, logic [31:0] alu, logic [31:0] rd, logic [2:0] lt);
      m_valid = v; m_pc = p; m_reg_write = rw; m_reg_addr = ra;
      m_wb_sel = sel; m_alu_result = alu; m_mem_rdata = rd; m_load_type = lt;
   endtask

   task automatic check_reset_values(string tag);
      chk({tag, ".reg_write"},  {31'd0, reg_write}, 32'd0);
      chk({tag, ".reg_addr"},   {27'd0, reg_addr},  32'd0);
      chk({tag, ".reg_data"},   reg_data,           32'd0);
      chk({tag, ".pc"},         pc,                 RESET_PC);
      chk({tag, ".w_valid"},    {31'd0, w_valid},   32'd0);
      chk({tag, ".misalign"},   {31'd0, misalign},  32'd0);
      chk({tag, ".retire_cnt"}, retire_cnt,         32'd0);
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      string       name;
      instr_t      in;
      logic        exp_rw;
      logic [4:0]  exp_ra;
      logic [31:0] exp_data;
   } vec_t;

   vec_t vecs[14];

   initial begin
      logic [31:0] held_data, held_cnt;

      vecs[0]  = '{"alu",      '{1, 32'h100,      1, 8,  0, 32'h1234,     32'h0,        0}, 1, 8,  32'h00001234};
      vecs[1]  = '{"lb_3",     '{1, 32'h104,      1, 5,  1, 32'h1003,     32'h80FF7F01, 1}, 1, 5,  32'hFFFFFF80};
      vecs[2]  = '{"lbu_2",    '{1, 32'h108,      1, 6,  1, 32'h1002,     32'h80FF7F01, 2}, 1, 6,  32'h000000FF};
      vecs[3]  = '{"lh_2",     '{1, 32'h10C,      1, 7,  1, 32'h1002,     32'h80FF7F01, 3}, 1, 7,  32'hFFFF80FF};
      vecs[4]  = '{"lhu_0",    '{1, 32'h110,      1, 9,  1, 32'h1000,     32'h80FF7F01, 4}, 1, 9,  32'h00007F01};
      vecs[5]  = '{"pc8",      '{1, 32'h00003000, 1, 31, 2, 32'h0,        32'h0,        0}, 1, 31, 32'h00003008};
      vecs[6]  = '{"pc8_wrap", '{1, 32'hFFFFFFFC, 1, 31, 2, 32'h0,        32'h0,        0}, 1, 31, 32'h00000004};
      vecs[7]  = '{"wr_r0",    '{1, 32'h114,      1, 0,  0, 32'h5,        32'h0,        0}, 0, 0,  32'h0};
      vecs[8]  = '{"rsvd_sel", '{1, 32'h118,      1, 3,  3, 32'hDEADBEEF, 32'h0,        0}, 1, 3,  32'hDEADBEEF};
      vecs[9]  = '{"lw",       '{1, 32'h11C,      1, 4,  1, 32'h2000,     32'h80FF7F01, 0}, 1, 4,  32'h80FF7F01};
      vecs[10] = '{"lt6_lw",   '{1, 32'h120,      1, 4,  1, 32'h2004,     32'h80FF7F01, 6}, 1, 4,  32'h80FF7F01};
      vecs[11] = '{"invalid",  '{0, 32'h124,      1, 4,  0, 32'h77,       32'h0,        0}, 0, 0,  32'h0};
      vecs[12] = '{"lb_0",     '{1, 32'h128,      1, 10, 1, 32'h3000,     32'h80FF7F01, 1}, 1, 10, 32'h00000001};
      vecs[13] = '{"lb_1",     '{1, 32'h12C,      1, 11, 1, 32'h3001,     32'h80FF7F01, 1}, 1, 11, 32'h0000007F};

      mdl_w = '0; mdl_mis = 1'b0; mdl_cnt = 32'd0;
      reset = 1'b1; en = 1'b1; flush = 1'b0;
      drive(1, 32'hABCD, 1, 12, 0, 32'h99, 32'h0, 0);
      step();
      step();
      check_reset_values("reset");
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].in.valid, vecs[i].in.pc, vecs[i].in.rw, vecs[i].in.ra,
               vecs[i].in.sel, vecs[i].in.alu, vecs[i].in.rdata, vecs[i].in.lt);
         step();
         chk({vecs[i].name, ".reg_write"}, {31'd0, reg_write}, {31'd0, vecs[i].exp_rw});
         chk({vecs[i].name, ".reg_addr"},  {27'd0, reg_addr},  {27'd0, vecs[i].exp_ra});
         chk({vecs[i].name, ".reg_data"},  reg_data,           vecs[i].exp_data);
         check_model(vecs[i].name);
      end
      chk("table.retire_cnt", retire_cnt, 32'd13);

      // hold for 3 cycles while M presents a different instruction
      drive(1, 32'h200, 1, 8, 0, 32'h1234, 32'h0, 0);
      step();
      held_data = reg_data;
      held_cnt  = retire_cnt;
      en = 1'b0;
      drive(1, 32'h300, 1, 20, 0, 32'h5555, 32'h0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold.reg_write",  {31'd0, reg_write}, 32'd1);
         chk("hold.reg_data",   reg_data,           held_data);
         chk("hold.pc",         pc,                 32'h200);
         chk("hold.retire_cnt", retire_cnt,         held_cnt);
      end
      flush = 1'b1;
      step();
      chk("flush.w_valid",   {31'd0, w_valid},   32'd0);
      chk("flush.reg_write", {31'd0, reg_write}, 32'd0);
      chk("flush.pc",        pc,                 RESET_PC);
      check_model("flush");
      flush = 1'b0;
      step();
      check_model("flush_hold");
      en = 1'b1;
      step();
      en = 1'b0;
      step();
      chk("hold2.reg_write", {31'd0, reg_write}, 32'd1);
      reset = 1'b1;
      step();
      check_reset_values("reset_held");
      reset = 1'b0;
      step();
      check_reset_values("after_reset_hold");
      en = 1'b1;

      // misaligned LW: write suppressed, flag sets on the next edge and sticks
      drive(1, 32'h400, 1, 9, 1, 32'h2, 32'h11223344, 0);
      step();
      chk("mis_lw.reg_write", {31'd0, reg_write}, 32'd0);
      chk("mis_lw.misalign",  {31'd0, misalign},  32'd0);
      drive(1, 32'h404, 1, 9, 0, 32'h42, 32'h0, 0);
      step();
      chk("mis_next.misalign",  {31'd0, misalign},  32'd1);
      chk("mis_next.reg_write", {31'd0, reg_write}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h408 + 32'(4 * i), 1, 3, 0, 32'(i), 32'h0, 0);
         step();
         chk("mis_sticky", {31'd0, misalign}, 32'd1);
      end
      drive(1, 32'h500, 1, 9, 1, 32'h1001, 32'h11223344, 4);
      step();
      chk("mis_lhu.reg_write", {31'd0, reg_write}, 32'd0);
      check_model("mis_lhu");
      reset = 1'b1;
      step();
      check_reset_values("mis_reset");
      reset = 1'b0;

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 7) == 0);
         en    = ($urandom_range(0, 3) != 0);
         drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
               ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
               2'($urandom), $urandom, $urandom, 3'($urandom));
         step();
         check_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
